// File: rtl/d5m_pkg.sv
// d5m_pkg: shared states, default geometry, pixel width and frame-size helper for the D5M capture scheduler
package d5m_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DROP} state_t;
  localparam int DEF_COLS = 800;
  localparam int DEF_LINES = 480;
  localparam int PX_W = 8;
  function automatic int total(input int cols, input int lines);
    return cols * lines;
  endfunction
endpackage

// File: rtl/d5m_wr_stage.sv
// d5m_wr_stage: single-entry holding register between the pixel stream and the valid/ready write port
module d5m_wr_stage
  import d5m_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [PX_W-1:0]   push_data,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PX_W-1:0]   wr_data,
  output logic              full,
  output logic              accept
);
  assign accept = push && (!full || wr_ready);
  assign wr_valid = full;
  // load on accept (draining the old entry in the same cycle), otherwise empty once the writer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (accept) begin
      full <= 1'b1;
      wr_addr <= push_addr;
      wr_data <= push_data;
    end else if (wr_ready) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/d5m_capture_scheduler.sv
// d5m_capture_scheduler: frame-aligned ping-pong capture of the D5M stream; optional D5M_SCHED_FRAME_SKIP_EN adds cfg_skip
module d5m_capture_scheduler
  import d5m_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int LINES = DEF_LINES,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_start,
  input  logic              cap_stop,
  input  logic              cfg_continuous,
  input  logic [ADDR_W-1:0] cfg_buf0_base,
  input  logic [ADDR_W-1:0] cfg_buf1_base,
  input  logic              px_valid,
  input  logic [PX_W-1:0]   px_data,
  input  logic              px_sop,
  input  logic              px_eop,
`ifdef D5M_SCHED_FRAME_SKIP_EN
  input  logic [3:0]        cfg_skip,
`endif
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PX_W-1:0]   wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              done_buf,
  output logic [15:0]       frame_count,
  output logic              err_overflow,
  output logic              err_framing
);
  localparam int TOT = total(COLS, LINES);
  localparam int IDX_W = $clog2(TOT + 1);

  state_t state, state_n, end_go;
  logic [IDX_W-1:0] idx, idx_eff;
  logic [ADDR_W-1:0] b0_r, b1_r, cur_b0, cur_b1, push_addr;
  logic active, cont_r, stop_pending;
  logic start_go, sop_go, restart, cap_px, first, cont_eff, stop_eff;
  logic last, good, complete, early, overflow, full, accept, eligible;

`ifdef D5M_SCHED_FRAME_SKIP_EN
  logic [3:0] skip_cnt;
  assign eligible = skip_cnt == 4'd0;
  // count SOPs seen while armed; only the frame that finds the counter at zero is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_cnt <= 4'd0;
    else if (start_go) skip_cnt <= 4'd0;
    else if (state == ARMED && px_valid && px_sop && !cap_stop) skip_cnt <= (skip_cnt >= cfg_skip) ? 4'd0 : skip_cnt + 4'd1;
  end
`else
  assign eligible = 1'b1;
`endif

  d5m_wr_stage #(.ADDR_W(ADDR_W)) u_wr (
    .clk(clk),
    .rst(rst),
    .push(cap_px),
    .push_addr(push_addr),
    .push_data(px_data),
    .wr_ready(wr_ready),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .full(full),
    .accept(accept)
  );

  assign busy = (state != IDLE) || full;

  // classify the current pixel and pick the next state; a SOP pixel uses live config, later pixels the sampled copy
  always_comb begin
    start_go = state == IDLE && cap_start && !cap_stop;
    sop_go = state == ARMED && px_valid && px_sop && !cap_stop && eligible;
    restart = state == CAPTURE && px_valid && px_sop;
    cap_px = sop_go || (state == CAPTURE && px_valid);
    first = sop_go || restart;
    idx_eff = first ? '0 : idx;
    cur_b0 = first ? cfg_buf0_base : b0_r;
    cur_b1 = first ? cfg_buf1_base : b1_r;
    cont_eff = first ? cfg_continuous : cont_r;
    push_addr = (active ? cur_b1 : cur_b0) + ADDR_W'(idx_eff);
    stop_eff = stop_pending || cap_stop;
    overflow = cap_px && !accept;
    last = idx_eff == IDX_W'(TOT - 1);
    good = cap_px && !overflow;
    complete = good && last;
    early = good && !last && px_eop;
    end_go = stop_eff ? IDLE : ARMED;
    state_n = state;
    if (state == IDLE) state_n = start_go ? ARMED : IDLE;
    else if (state == DROP) state_n = (px_valid && px_eop) ? end_go : DROP;
    else if (cap_px) state_n = overflow ? (px_eop ? end_go : DROP) : complete ? ((cont_eff && !stop_eff) ? ARMED : IDLE) : early ? end_go : CAPTURE;
    else if (state == ARMED && cap_stop) state_n = IDLE;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  // frame bookkeeping: index, sampled config, buffer ownership, completion pulse, sticky errors, pending stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      b0_r <= '0;
      b1_r <= '0;
      cont_r <= 1'b0;
      active <= 1'b0;
      stop_pending <= 1'b0;
      frame_done <= 1'b0;
      done_buf <= 1'b0;
      frame_count <= 16'd0;
      err_overflow <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      frame_done <= complete;
      if (complete) begin
        done_buf <= active;
        frame_count <= frame_count + 16'd1;
        active <= ~active;
      end
      if (start_go) begin
        active <= 1'b0;
        err_overflow <= 1'b0;
        err_framing <= 1'b0;
      end else begin
        if (overflow) err_overflow <= 1'b1;
        if ((good && (last != px_eop)) || restart) err_framing <= 1'b1;
      end
      if (first) begin
        b0_r <= cfg_buf0_base;
        b1_r <= cfg_buf1_base;
        cont_r <= cfg_continuous;
      end
      if (cap_px) idx <= idx_eff + 1'b1;
      stop_pending <= (state_n == IDLE) ? 1'b0 : stop_pending || (cap_stop && (state == CAPTURE || state == DROP));
    end
  end
endmodule

// File: tb/tb_d5m_capture_scheduler.sv
// tb_d5m_capture_scheduler: table-driven and randomized frame-level checks of the capture scheduler (COLS=4, LINES=2)
module tb_d5m_capture_scheduler;
  typedef struct {
    int start; int cont; int eop; int stop; int stall;
    int nw; logic [31:0] base; int nd; int dbuf; int cnt;
    int ferr; int ovf; int busy;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cap_start = 0, cap_stop = 0, cfg_continuous = 0;
  logic [31:0] cfg_buf0_base = 32'h1000, cfg_buf1_base = 32'h2000;
  logic px_valid = 0, px_sop = 0, px_eop = 0, wr_ready = 1;
  logic [7:0] px_data = 0;
`ifdef D5M_SCHED_FRAME_SKIP_EN
  logic [3:0] cfg_skip = 0;
`endif
  logic wr_valid, busy, frame_done, done_buf, err_overflow, err_framing;
  logic [31:0] wr_addr;
  logic [7:0] wr_data;
  logic [15:0] frame_count;

  int checks = 0, errors = 0;
  logic [39:0] wq[$];
  logic [16:0] dq[$];
  logic [7:0] sent[8];
  logic [31:0] sb0, sb1;
  vec_t vecs[13];
  vec_t v;

  d5m_capture_scheduler #(.COLS(4), .LINES(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .cap_start(cap_start), .cap_stop(cap_stop),
    .cfg_continuous(cfg_continuous), .cfg_buf0_base(cfg_buf0_base), .cfg_buf1_base(cfg_buf1_base),
    .px_valid(px_valid), .px_data(px_data), .px_sop(px_sop), .px_eop(px_eop),
`ifdef D5M_SCHED_FRAME_SKIP_EN
    .cfg_skip(cfg_skip),
`endif
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .frame_done(frame_done), .done_buf(done_buf), .frame_count(frame_count),
    .err_overflow(err_overflow), .err_framing(err_framing)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data});
      if (frame_done) dq.push_back({done_buf, frame_count});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic send_frame(input int eop_idx, input int stop_idx, input int stall_idx, input bit gaps, input bit mut);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      sent[i] = 8'($urandom);
      if (i == 0) begin sb0 = cfg_buf0_base; sb1 = cfg_buf1_base; end
      px_valid = 1; px_data = sent[i]; px_sop = (i == 0); px_eop = (i == eop_idx);
      cap_stop = (i == stop_idx);
      wr_ready = !(stall_idx >= 0 && (i == stall_idx || i == stall_idx + 1));
      tick();
      px_valid = 0; px_sop = 0; px_eop = 0; cap_stop = 0; wr_ready = 1;
      if (mut && i == 0) begin cfg_buf0_base = $urandom; cfg_buf1_base = $urandom; end
    end
    repeat (4) tick();
  endtask

  task automatic check_io(input string tag, input int nw, input logic [31:0] base, input int nd, input int dbuf, input int cnt);
    chk({tag, " nwrites"}, 64'(wq.size()), 64'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++) chk({tag, " write"}, 64'(wq[i]), {24'd0, base + 32'(i), sent[i]});
    chk({tag, " ndone"}, 64'(dq.size()), 64'(nd));
    if (nd > 0 && dq.size() > 0) chk({tag, " done"}, 64'(dq[0]), 64'({dbuf[0], 16'(cnt)}));
    chk({tag, " count"}, 64'(frame_count), 64'(16'(cnt)));
    wq.delete();
    dq.delete();
  endtask

  initial begin
    int m_active, m_count, m_ferr, eop_idx, early;
    logic [31:0] eb;
    vecs[0]  = '{1, 0, 7, -1, -1, 8, 32'h1000, 1, 0, 1, 0, 0, 0};
    vecs[1]  = '{0, 0, 7, -1, -1, 0, 32'h1000, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{1, 1, 7, -1, -1, 8, 32'h1000, 1, 0, 2, 0, 0, 1};
    vecs[3]  = '{0, 1, 7, -1, -1, 8, 32'h2000, 1, 1, 3, 0, 0, 1};
    vecs[4]  = '{0, 1, 7, -1, -1, 8, 32'h1000, 1, 0, 4, 0, 0, 1};
    vecs[5]  = '{0, 1, 5, -1, -1, 6, 32'h2000, 0, 0, 4, 1, 0, 1};
    vecs[6]  = '{0, 1, 7, -1, -1, 8, 32'h2000, 1, 1, 5, 1, 0, 1};
    vecs[7]  = '{0, 1, 7, -1,  3, 3, 32'h1000, 0, 0, 5, 1, 1, 1};
    vecs[8]  = '{0, 1, 7, -1, -1, 8, 32'h1000, 1, 0, 6, 1, 1, 1};
    vecs[9]  = '{0, 1, 7,  3, -1, 8, 32'h2000, 1, 1, 7, 1, 1, 0};
    vecs[10] = '{0, 1, 7, -1, -1, 0, 32'h2000, 0, 0, 7, 1, 1, 0};
    vecs[11] = '{1, 0, -1, -1, -1, 8, 32'h1000, 1, 0, 8, 1, 0, 0};
    vecs[12] = '{1, 0, 7, -1, -1, 8, 32'h1000, 1, 0, 9, 0, 0, 0};

    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset wr_valid", 64'(wr_valid), 0);
    chk("reset busy", 64'(busy), 0);
    chk("reset frame_done", 64'(frame_done), 0);
    chk("reset done_buf", 64'(done_buf), 0);
    chk("reset count", 64'(frame_count), 0);
    chk("reset errs", 64'({err_overflow, err_framing}), 0);

    cap_start = 1; cap_stop = 1;
    tick();
    cap_start = 0; cap_stop = 0;
    chk("start+stop busy", 64'(busy), 0);
    send_frame(7, -1, -1, 0, 0);
    check_io("start+stop", 0, 32'h1000, 0, 0, 0);

    for (int k = 0; k < 13; k++) begin
      v = vecs[k];
      cfg_continuous = v.cont[0];
      if (v.start != 0) begin cap_start = 1; tick(); cap_start = 0; end
      send_frame(v.eop, v.stop, v.stall, 0, 0);
      check_io($sformatf("vec%0d", k), v.nw, v.base, v.nd, v.dbuf, v.cnt);
      chk($sformatf("vec%0d err_framing", k), 64'(err_framing), 64'(v.ferr));
      chk($sformatf("vec%0d err_overflow", k), 64'(err_overflow), 64'(v.ovf));
      chk($sformatf("vec%0d busy", k), 64'(busy), 64'(v.busy));
    end

    cfg_continuous = 1; cfg_buf0_base = 32'h1000; cfg_buf1_base = 32'hFFFF_FFFC;
    cap_start = 1; tick(); cap_start = 0;
    m_active = 0; m_count = 9; m_ferr = 0;
    for (int k = 0; k < 24; k++) begin
      early = (k >= 2) && ($urandom_range(0, 3) == 0);
      eop_idx = (early != 0) ? int'($urandom_range(1, 6)) : 7;
      send_frame(eop_idx, -1, -1, 1, k >= 1);
      eb = (m_active != 0) ? sb1 : sb0;
      if (early == 0) m_count++;
      check_io($sformatf("rnd%0d", k), eop_idx + 1, eb, (early != 0) ? 0 : 1, m_active, m_count);
      if (early == 0) m_active ^= 1;
      m_ferr |= early;
      chk($sformatf("rnd%0d err_framing", k), 64'(err_framing), 64'(m_ferr));
    end

    cfg_continuous = 0; cfg_buf0_base = 32'h1000; cfg_buf1_base = 32'h2000;
    cap_start = 1; tick(); cap_start = 0;
    for (int i = 0; i < 4; i++) begin
      px_valid = 1; px_sop = (i == 0); px_data = 8'(i);
      tick();
    end
    px_valid = 0; px_sop = 0;
    rst = 1;
    #1;
    chk("midreset wr_valid", 64'(wr_valid), 0);
    chk("midreset busy", 64'(busy), 0);
    chk("midreset count", 64'(frame_count), 0);
    chk("midreset errs", 64'({err_overflow, err_framing, frame_done}), 0);
    repeat (2) tick();
    rst = 0;
    tick();
    wq.delete();
    dq.delete();

`ifdef D5M_SCHED_FRAME_SKIP_EN
    cfg_skip = 4'd2; cfg_continuous = 1;
    cap_start = 1; tick(); cap_start = 0;
    for (int k = 0; k < 6; k++) begin
      send_frame(7, -1, -1, 0, 0);
      check_io($sformatf("skip%0d", k), (k % 3 == 0) ? 8 : 0, ((k / 3) % 2 != 0) ? 32'h2000 : 32'h1000,
               (k % 3 == 0) ? 1 : 0, (k / 3) % 2, k / 3 + 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
